// File: rtl/ms_pkg.sv
// Shared types and maze constants for the maze-solver path stages.
package ms_pkg;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } coord_t;

    localparam logic [3:0] START_X  = 4'd1;
    localparam logic [3:0] START_Y  = 4'd1;
    localparam logic [3:0] GOAL_X   = 4'd13;
    localparam logic [3:0] GOAL_Y   = 4'd13;
    localparam logic [3:0] MAZE_DIM = 4'd15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REPLAY  = 2'd2,
        REPORT  = 2'd3
    } state_t;

endpackage

// File: rtl/ms_lifo.sv
// Register-based coordinate stack. The top entry is always visible
// combinationally; push and pop are never requested in the same cycle.
module ms_lifo
    import ms_pkg::*;
#(
    parameter int DEPTH = 169,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  coord_t           din,
    output coord_t           top,
    output logic [LEN_W-1:0] count,
    output logic             empty,
    output logic             full
);

    coord_t mem [DEPTH];

    assign empty = (count == '0);
    assign full  = (count == LEN_W'(DEPTH));
    assign top   = empty ? '0 : mem[count - LEN_W'(1)];

    // Stack storage: data only, so it is left out of the reset.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[count] <= din;
        end
    end

    // Entry counter: saturates at DEPTH on push, stops at zero on pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + LEN_W'(1);
        end else if (pop && !empty) begin
            count <= count - LEN_W'(1);
        end
    end

endmodule

// File: rtl/ms_path_reverser.sv
// Path reverser: captures the solver's goal-to-start burst in a LIFO and
// replays it start-to-goal over valid/ready, then reports length and status.
// Optional build macro MS_PATH_CHECK_EN adds path-shape checking
// (goal first, start last, 4-adjacency, no border cells) into path_err.
module ms_path_reverser
    import ms_pkg::*;
#(
    parameter int DEPTH = 169,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_not_valid,
    input  logic [3:0]       in_x,
    input  logic [3:0]       in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_x,
    output logic [3:0]       out_y,
    output logic             out_last,
    output logic             done,
    output logic [LEN_W-1:0] path_len,
    output logic             path_err,
    output logic             no_path
);

    state_t           state;
    coord_t           in_c;
    coord_t           top;
    logic [LEN_W-1:0] count;
    logic             empty;
    logic             full;
    logic             push;
    logic             load;
    logic             err_q;
    logic [LEN_W-1:0] len_q;
    logic             chk_in_err;
    logic             chk_end_err;

    assign in_c = '{x: in_x, y: in_y};
    assign push = in_valid && ((state == IDLE) || (state == COLLECT));
    // Output register takes the next entry whenever it is empty or draining.
    assign load = (state == REPLAY) && !empty && (!out_valid || out_ready);

    ms_lifo #(
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) u_lifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (load),
        .din   (in_c),
        .top   (top),
        .count (count),
        .empty (empty),
        .full  (full)
    );

`ifdef MS_PATH_CHECK_EN
    coord_t prev_q;

    function automatic logic is_border(input coord_t c);
        return (c.x == 4'd0) || (c.x == MAZE_DIM - 4'd1) ||
               (c.y == 4'd0) || (c.y == MAZE_DIM - 4'd1);
    endfunction

    function automatic logic not_adjacent(input coord_t a, input coord_t b);
        logic signed [4:0] dx;
        logic signed [4:0] dy;
        logic        [4:0] adx;
        logic        [4:0] ady;
        logic        [5:0] dist;
        dx   = $signed({1'b0, b.x}) - $signed({1'b0, a.x});
        dy   = $signed({1'b0, b.y}) - $signed({1'b0, a.y});
        adx  = dx[4] ? 5'(-dx) : 5'(dx);
        ady  = dy[4] ? 5'(-dy) : 5'(dy);
        dist = {1'b0, adx} + {1'b0, ady};
        return dist != 6'd1;
    endfunction

    assign chk_in_err = in_valid && (is_border(in_c) ||
                        ((state == IDLE) ? ((in_c.x != GOAL_X) || (in_c.y != GOAL_Y))
                                         : not_adjacent(prev_q, in_c)));
    assign chk_end_err = (state == COLLECT) && !in_valid &&
                         ((prev_q.x != START_X) || (prev_q.y != START_Y));

    // Remember the previous accepted coordinate for adjacency and end checks.
    always_ff @(posedge clk) begin
        if (push) begin
            prev_q <= in_c;
        end
    end
`else
    assign chk_in_err  = 1'b0;
    assign chk_end_err = 1'b0;
`endif

    // Job sequencer with registered replay and report outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            err_q     <= 1'b0;
            len_q     <= '0;
            out_valid <= 1'b0;
            out_x     <= 4'd0;
            out_y     <= 4'd0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            path_len  <= '0;
            path_err  <= 1'b0;
            no_path   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done      <= 1'b0;
                    path_len  <= '0;
                    path_err  <= 1'b0;
                    no_path   <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    out_x     <= 4'd0;
                    out_y     <= 4'd0;
                    if (in_valid) begin
                        state <= COLLECT;
                        err_q <= in_not_valid | chk_in_err;
                    end else if (in_not_valid) begin
                        state   <= REPORT;
                        done    <= 1'b1;
                        no_path <= 1'b1;
                        err_q   <= 1'b0;
                    end else begin
                        err_q <= 1'b0;
                    end
                end
                COLLECT: begin
                    err_q <= err_q | (in_valid & full) | in_not_valid |
                             chk_in_err | chk_end_err;
                    if (!in_valid) begin
                        state <= REPLAY;
                        len_q <= count;
                    end
                end
                REPLAY: begin
                    if (load) begin
                        out_valid <= 1'b1;
                        out_x     <= top.x;
                        out_y     <= top.y;
                        out_last  <= (count == LEN_W'(1));
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        out_x     <= 4'd0;
                        out_y     <= 4'd0;
                        state     <= REPORT;
                        done      <= 1'b1;
                        path_len  <= len_q;
                        path_err  <= err_q;
                        no_path   <= 1'b0;
                    end
                end
                REPORT: begin
                    done     <= 1'b0;
                    path_len <= '0;
                    path_err <= 1'b0;
                    no_path  <= 1'b0;
                    err_q    <= 1'b0;
                    len_q    <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ms_path_reverser.sv
// Bench for ms_path_reverser: queue-based reference (stored = first DEPTH
// coordinates, replay = reverse order) with randomized paths and ready.
module tb_ms_path_reverser;
    import ms_pkg::*;

    localparam int DEPTH = 169;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_not_valid;
    logic [3:0]       in_x;
    logic [3:0]       in_y;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_x;
    logic [3:0]       out_y;
    logic             out_last;
    logic             done;
    logic [LEN_W-1:0] path_len;
    logic             path_err;
    logic             no_path;

    int errors = 0;
    int checks = 0;

    coord_t           stim_q[$];
    coord_t           got_q[$];
    bit               got_last[$];
    bit               got_done;
    logic [LEN_W-1:0] got_len;
    logic             got_err;
    logic             got_np;
    int               stall_bad;
    int               first_vld;
    bit               timed_out;

    always #5 clk = ~clk;

    ms_path_reverser #(
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_not_valid (in_not_valid),
        .in_x         (in_x),
        .in_y         (in_y),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_x        (out_x),
        .out_y        (out_y),
        .out_last     (out_last),
        .done         (done),
        .path_len     (path_len),
        .path_err     (path_err),
        .no_path      (no_path)
    );

`ifdef MS_PATH_CHECK_EN
    function automatic bit path_rule_err(input coord_t p[$]);
        bit e = 0;
        int dx, dy;
        if (p.size() == 0) return 0;
        if (p[0].x != 4'd13 || p[0].y != 4'd13) e = 1;
        if (p[p.size()-1].x != 4'd1 || p[p.size()-1].y != 4'd1) e = 1;
        for (int i = 0; i < p.size(); i++) begin
            if (p[i].x == 0 || p[i].x == 14 || p[i].y == 0 || p[i].y == 14) e = 1;
            if (i > 0) begin
                dx = int'(p[i].x) - int'(p[i-1].x);
                dy = int'(p[i].y) - int'(p[i-1].y);
                if (dx < 0) dx = -dx;
                if (dy < 0) dy = -dy;
                if (dx + dy != 1) e = 1;
            end
        end
        return e;
    endfunction
`endif

    task automatic make_straight();
        coord_t c;
        stim_q.delete();
        for (int y = 13; y >= 1; y--) begin c.x = 4'd13; c.y = 4'(y); stim_q.push_back(c); end
        for (int x = 12; x >= 1; x--) begin c.x = 4'(x); c.y = 4'd1; stim_q.push_back(c); end
    endtask

    task automatic make_gap2();
        coord_t c;
        stim_q.delete();
        for (int y = 13; y >= 1; y -= 2) begin c.x = 4'd13; c.y = 4'(y); stim_q.push_back(c); end
        for (int x = 11; x >= 1; x -= 2) begin c.x = 4'(x); c.y = 4'd1; stim_q.push_back(c); end
    endtask

    task automatic make_random_walk(input int n);
        coord_t c;
        int x = 13, y = 13, d;
        stim_q.delete();
        for (int i = 0; i < n; i++) begin
            c.x = 4'(x); c.y = 4'(y);
            stim_q.push_back(c);
            d = $urandom_range(0, 3);
            case (d)
                0: x = (x > 1)  ? x - 1 : x + 1;
                1: y = (y > 1)  ? y - 1 : y + 1;
                2: x = (x < 13) ? x + 1 : x - 1;
                default: y = (y < 13) ? y + 1 : y - 1;
            endcase
        end
    endtask

    // Drive stim_q as one contiguous burst; optionally raise in_not_valid with beat 0.
    task automatic send_burst(input bit both_first);
        for (int i = 0; i < stim_q.size(); i++) begin
            @(negedge clk);
            in_valid     = 1'b1;
            in_not_valid = both_first && (i == 0);
            in_x         = stim_q[i].x;
            in_y         = stim_q[i].y;
        end
        @(negedge clk);
        in_valid     = 1'b0;
        in_not_valid = 1'b0;
        in_x         = 4'd0;
        in_y         = 4'd0;
    endtask

    // Consume replay beats with a ready pattern until done, a beat limit, or the budget.
    task automatic collect(input int mode, input int max_beats, input int budget);
        coord_t pc;
        bit     pl = 0;
        bit     pstall = 0;
        bit     r;
        int     cyc = 0;
        got_q.delete(); got_last.delete();
        got_done = 0; got_len = '0; got_err = 0; got_np = 0;
        stall_bad = 0; first_vld = -1; timed_out = 0;
        pc = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc > budget) begin timed_out = 1; out_ready = 1'b0; break; end
            if (done) begin
                got_done = 1; got_len = path_len; got_err = path_err; got_np = no_path;
                out_ready = 1'b0;
                break;
            end
            if (out_valid) begin
                if (first_vld < 0) first_vld = cyc;
                if (pstall && ({out_x, out_y, out_last} != {pc.x, pc.y, pl})) stall_bad++;
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            pstall = out_valid && !r;
            pc.x = out_x; pc.y = out_y; pl = out_last;
            if (out_valid && r) begin
                pc.x = out_x; pc.y = out_y;
                got_q.push_back(pc);
                got_last.push_back(out_last);
                if (got_q.size() == max_beats) break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_not_valid = 1'b0;
        in_x = 4'd0; in_y = 4'd0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, out_x, out_y, out_last, done, path_len, path_err, no_path} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0",
                     {out_valid, out_x, out_y, out_last, done, path_len, path_err, no_path});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, done} !== 2'b00) begin
            errors++; $display("FAIL reset_idle got=%b want=00", {out_valid, done});
        end
    endtask

    // One full job from stim_q with full-reference checking of replay and report.
    task automatic test_replay(input string name, input int mode, input bit both_first);
        int exp_n, bad_seq, bad_last;
        bit exp_err;
        exp_n   = (stim_q.size() > DEPTH) ? DEPTH : stim_q.size();
        exp_err = (stim_q.size() > DEPTH) || both_first;
`ifdef MS_PATH_CHECK_EN
        exp_err = exp_err || path_rule_err(stim_q);
`endif
        send_burst(both_first);
        collect(mode, 1 << 20, 4000);

        checks++;
        if (timed_out || !got_done) begin
            errors++; $display("FAIL %s_done timeout=%0d done=%0d want done=1", name, timed_out, got_done);
        end
        checks++;
        if (first_vld != 2) begin
            errors++; $display("FAIL %s_latency got=%0d want=2", name, first_vld);
        end
        checks++;
        if (got_q.size() != exp_n) begin
            errors++; $display("FAIL %s_beats got=%0d want=%0d", name, got_q.size(), exp_n);
        end
        bad_seq = 0; bad_last = 0;
        for (int i = 0; i < got_q.size() && i < exp_n; i++) begin
            if (got_q[i] !== stim_q[exp_n-1-i]) begin
                if (bad_seq == 0)
                    $display("FAIL %s_seq beat=%0d got=(%0d,%0d) want=(%0d,%0d)", name, i,
                             got_q[i].x, got_q[i].y, stim_q[exp_n-1-i].x, stim_q[exp_n-1-i].y);
                bad_seq++;
            end
            if (got_last[i] != (i == exp_n - 1)) bad_last++;
        end
        checks++;
        if (bad_seq != 0) errors++;
        checks++;
        if (bad_last != 0) begin
            errors++; $display("FAIL %s_last bad_beats=%0d want=0", name, bad_last);
        end
        checks++;
        if (stall_bad != 0) begin
            errors++; $display("FAIL %s_stall_stable changes=%0d want=0", name, stall_bad);
        end
        checks++;
        if (got_len !== LEN_W'(exp_n) || got_err !== exp_err || got_np !== 1'b0) begin
            errors++;
            $display("FAIL %s_report got len=%0d err=%0d np=%0d want len=%0d err=%0d np=0",
                     name, got_len, got_err, got_np, exp_n, exp_err);
        end
        @(negedge clk);
        checks++;
        if ({done, path_len, path_err, out_valid} !== '0) begin
            errors++; $display("FAIL %s_done_pulse done=%0d len=%0d want 0", name, done, path_len);
        end
    endtask

    task automatic test_no_path();
        @(negedge clk);
        in_not_valid = 1'b1;
        @(negedge clk);
        in_not_valid = 1'b0;
        checks++;
        if ({done, no_path, path_len, path_err, out_valid} !== {2'b11, LEN_W'(0), 2'b00}) begin
            errors++;
            $display("FAIL nopath_report got done=%0d np=%0d len=%0d err=%0d ov=%0d want 1 1 0 0 0",
                     done, no_path, path_len, path_err, out_valid);
        end
        @(negedge clk);
        checks++;
        if ({done, no_path, out_valid} !== 3'b000) begin
            errors++; $display("FAIL nopath_clear got=%b want=000", {done, no_path, out_valid});
        end
    endtask

    task automatic test_reset_mid_replay();
        make_straight();
        send_burst(1'b0);
        collect(0, 3, 200);
        checks++;
        if (got_q.size() != 3 || got_q[0] !== stim_q[24]) begin
            errors++; $display("FAIL midrst_pre beats=%0d want=3", got_q.size());
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_x, out_y, out_last, done} !== '0) begin
            errors++; $display("FAIL midrst_async got=%h want=0", {out_valid, out_x, out_y, out_last, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        stim_q.delete();
        stim_q.push_back('{x: 4'd3, y: 4'd1});
        stim_q.push_back('{x: 4'd2, y: 4'd1});
        stim_q.push_back('{x: 4'd1, y: 4'd1});
        test_replay("post_reset", 0, 1'b0);
    endtask

    initial begin
        test_reset();
        make_straight();          test_replay("straight", 0, 1'b0);
        make_straight();          test_replay("stall", 1, 1'b0);
        test_no_path();
        make_straight();          test_replay("both_inputs", 0, 1'b1);
        make_random_walk(DEPTH + 1); test_replay("overflow", 0, 1'b0);
        make_gap2();              test_replay("gap2", 0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            make_random_walk($urandom_range(1, 60));
            test_replay("random", 2, 1'b0);
        end
        test_reset_mid_replay();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
